// File: rtl/vga_timing_pkg.sv
// Shared timing constants, phase encoding and boundary helper
// for the VGA raster timing generator (default 640x480@60 Hz).
package vga_timing_pkg;

    // Every raster coordinate fits in this width (totals <= 1023).
    localparam int CNT_W = 10;

    // Default 640x480@60 Hz timing.
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_e;

    // Last count value of each phase along one axis.
    typedef struct packed {
        logic [CNT_W-1:0] act_end;
        logic [CNT_W-1:0] fp_end;
        logic [CNT_W-1:0] sync_end;
        logic [CNT_W-1:0] bp_end;
    } bounds_t;

    function automatic bounds_t phase_bounds(
        input int active,
        input int fp,
        input int sync,
        input int bp
    );
        bounds_t b;
        b.act_end  = CNT_W'(active - 1);
        b.fp_end   = CNT_W'(active + fp - 1);
        b.sync_end = CNT_W'(active + fp + sync - 1);
        b.bp_end   = CNT_W'(active + fp + sync + bp - 1);
        return b;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster output bundle of the VGA timing generator.
// master: generator side (takes pix_ce, drives raster outputs).
// slave:  consumer side (drives pix_ce, samples raster outputs).
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int FRAME_W = 8
);
    logic               pix_ce;
    logic [CNT_W-1:0]   pixel_x;
    logic [CNT_W-1:0]   pixel_y;
    logic               video_en;
    logic               hsync;
    logic               vsync;
    logic               line_start;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        input  pix_ce,
        output pixel_x,
        output pixel_y,
        output video_en,
        output hsync,
        output vsync,
        output line_start,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output pix_ce,
        input  pixel_x,
        input  pixel_y,
        input  video_en,
        input  hsync,
        input  vsync,
        input  line_start,
        input  frame_start,
        input  frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACTIVE/FP/SYNC/BP phase FSM.
// Ports: clk, rst (async, active-high), step (advance one position);
//        count, phase, in_active, in_sync, wrap (step at last position).
// Every phase width must be at least 1.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output phase_e           phase,
    output logic             in_active,
    output logic             in_sync,
    output logic             wrap
);

    localparam bounds_t B = phase_bounds(ACTIVE, FP, SYNC, BP);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    phase_e           phase_q;
    phase_e           phase_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            phase_q <= PH_ACTIVE;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign wrap = step && (count_q == B.bp_end);

    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + 1'b1;
            // Leave a phase on its last position so the phase
            // always describes the current count.
            unique case (phase_q)
                PH_ACTIVE: if (count_q == B.act_end)  phase_d = PH_FP;
                PH_FP:     if (count_q == B.fp_end)   phase_d = PH_SYNC;
                PH_SYNC:   if (count_q == B.sync_end) phase_d = PH_BP;
                PH_BP:     if (count_q == B.bp_end)   phase_d = PH_ACTIVE;
                default:   phase_d = PH_ACTIVE;
            endcase
        end
    end

    assign count     = count_q;
    assign phase     = phase_q;
    assign in_active = (phase_q == PH_ACTIVE);
    assign in_sync   = (phase_q == PH_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel coordinates, video enable, syncs and
// line/frame pulses, all registered and loaded once per pix_ce.
// Ports: clk, rst (async, active-high), vga (master: pix_ce in, raster out).
// Macro VGA_TIMING_FRAME_CNT_EN adds the frame counter; otherwise frame_cnt=0.
// H and V totals must each be <= 1023.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_NEG = 1'b1,
    parameter int FRAME_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    vga_timing_gen_if.master vga
);

    // Level a sync output rests at outside its pulse.
    localparam logic SYNC_IDLE = SYNC_NEG;

    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_e           h_phase;
    phase_e           v_phase;
    logic             h_in_active;
    logic             v_in_active;
    logic             h_in_sync;
    logic             v_in_sync;
    logic             h_wrap;
    logic             v_wrap;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk       (clk),
        .rst       (rst),
        .step      (vga.pix_ce),
        .count     (h_count),
        .phase     (h_phase),
        .in_active (h_in_active),
        .in_sync   (h_in_sync),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk       (clk),
        .rst       (rst),
        .step      (h_wrap),
        .count     (v_count),
        .phase     (v_phase),
        .in_active (v_in_active),
        .in_sync   (v_in_sync),
        .wrap      (v_wrap)
    );

    logic [CNT_W-1:0] px_q, px_d;
    logic [CNT_W-1:0] py_q, py_d;
    logic             ven_q, ven_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             ls_q, ls_d;
    logic             fs_q, fs_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q  <= '0;
            py_q  <= '0;
            ven_q <= 1'b0;
            hs_q  <= SYNC_IDLE;
            vs_q  <= SYNC_IDLE;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            px_q  <= px_d;
            py_q  <= py_d;
            ven_q <= ven_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
        end
    end

    // Outputs are the decode of the counter position being left,
    // so they trail the counters by exactly one pix_ce.
    always_comb begin
        px_d  = px_q;
        py_d  = py_q;
        ven_d = ven_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        ls_d  = 1'b0;
        fs_d  = 1'b0;
        if (vga.pix_ce) begin
            px_d  = h_count;
            py_d  = v_count;
            ven_d = h_in_active && v_in_active;
            hs_d  = SYNC_NEG ? ~h_in_sync : h_in_sync;
            vs_d  = SYNC_NEG ? ~v_in_sync : v_in_sync;
            ls_d  = (h_count == '0);
            fs_d  = (h_count == '0) && (v_count == '0);
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FRAME_W-1:0] fc_q, fc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    // Counts up on the clock after each frame_start pulse, so the
    // value seen alongside a frame_start is the number of earlier frames.
    always_comb begin
        fc_d = fc_q;
        if (fs_q) begin
            fc_d = fc_q + 1'b1;
        end
    end

    assign vga.frame_cnt = fc_q;
`else
    assign vga.frame_cnt = '0;
`endif

    assign vga.pixel_x     = px_q;
    assign vga.pixel_y     = py_q;
    assign vga.video_en    = ven_q;
    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;

    // Phase flags and the frame wrap must agree with the axis state.
    a_h_phase : assert property (@(posedge clk) disable iff (rst)
        h_in_active == (h_phase == PH_ACTIVE));
    a_v_phase : assert property (@(posedge clk) disable iff (rst)
        v_in_active == (v_phase == PH_ACTIVE));
    a_v_wrap : assert property (@(posedge clk) disable iff (rst)
        v_wrap |-> h_wrap);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so many frames fit.
// Reference is computed from raster arithmetic on an (h,v) position.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit SN = 1'b1;
    localparam int FW = 2;

    typedef struct packed {
        logic [9:0]    px;
        logic [9:0]    py;
        logic          ven;
        logic          hs;
        logic          vs;
        logic          ls;
        logic          fs;
        logic [FW-1:0] fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_gen_if #(.FRAME_W(FW)) vif ();

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_NEG (SN), .FRAME_W (FW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vga (vif)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];

    // Reference model state
    int   hh, vv, frames;
    bit   prev_fs;
    bit   mid_done;
    exp_t cur;

    function automatic exp_t rst_val();
        exp_t e;
        e     = '0;
        e.hs  = SN;
        e.vs  = SN;
        return e;
    endfunction

    function automatic exp_t sample();
        exp_t e;
        e.px  = vif.pixel_x;
        e.py  = vif.pixel_y;
        e.ven = vif.video_en;
        e.hs  = vif.hsync;
        e.vs  = vif.vsync;
        e.ls  = vif.line_start;
        e.fs  = vif.frame_start;
        e.fc  = vif.frame_cnt;
        return e;
    endfunction

    function automatic void model_reset();
        hh      = 0;
        vv      = 0;
        frames  = 0;
        prev_fs = 1'b0;
        cur     = rst_val();
    endfunction

    // Expected outputs after the next clock edge.
    function automatic exp_t model_step(bit ce);
        bit hin, vin;
        if (!ce) begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
        end else begin
            hin     = (hh >= HA + HF) && (hh < HA + HF + HS);
            vin     = (vv >= VA + VF) && (vv < VA + VF + VS);
            cur.px  = 10'(hh);
            cur.py  = 10'(vv);
            cur.ven = (hh < HA) && (vv < VA);
            cur.hs  = SN ? !hin : hin;
            cur.vs  = SN ? !vin : vin;
            cur.ls  = (hh == 0);
            cur.fs  = (hh == 0) && (vv == 0);
            hh = hh + 1;
            if (hh == HT) begin
                hh = 0;
                vv = (vv + 1) % VT;
            end
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        if (prev_fs) frames = frames + 1;
        cur.fc  = FW'(frames % (1 << FW));
`else
        cur.fc  = '0;
`endif
        prev_fs = cur.fs;
        return cur;
    endfunction

    task automatic check_reset(input string name);
        exp_t g;
        g = sample();
        n_chk++;
        if (g !== rst_val()) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, g, rst_val());
        end
    endtask

    // One clock of stimulus, issued just after the falling edge.
    task automatic cycle(input bit ce, input bit r);
        bit was_rst;
        @(negedge clk);
        #1;
        was_rst    = rst;
        rst        = r;
        vif.pix_ce = ce;
        if (r) begin
            model_reset();
            q.push_back(cur);
            if (!was_rst) begin
                #1;
                check_reset("rst_async");
            end
        end else begin
            q.push_back(model_step(ce));
        end
    endtask

    // Monitor: every falling edge compares the DUT against the oldest expectation.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                g = sample();
                n_chk++;
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL raster @%0t: got x=%0d y=%0d ven=%b hs=%b vs=%b ls=%b fs=%b fc=%0d expected x=%0d y=%0d ven=%b hs=%b vs=%b ls=%b fs=%b fc=%0d",
                             $time, g.px, g.py, g.ven, g.hs, g.vs, g.ls, g.fs, g.fc,
                             e.px, e.py, e.ven, e.hs, e.vs, e.ls, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        bit ce, r;
        int rst_left;
        vif.pix_ce = 1'b0;
        mid_done   = 1'b0;
        rst_left   = 0;
        model_reset();
        @(negedge clk);
        #1;
        check_reset("reset");

        // Free-running pixel clock: release reset with pix_ce high.
        for (int i = 0; i < 700; i++) cycle(1'b1, 1'b0);

        // pix_ce on every second clock.
        for (int i = 0; i < 700; i++) cycle(i[0], 1'b0);

        // Random pix_ce, a forced mid-frame reset and occasional random resets.
        for (int i = 0; i < 5000; i++) begin
            ce = ($urandom_range(0, 99) < 75);
            r  = 1'b0;
            if (rst_left > 0) begin
                rst_left--;
                r = 1'b1;
            end else if (!mid_done && hh == 10 && vv == 3) begin
                mid_done = 1'b1;
                rst_left = 1;
                r        = 1'b1;
            end else if ($urandom_range(0, 999) == 0) begin
                rst_left = int'($urandom_range(0, 2));
                r        = 1'b1;
            end
            cycle(ce, r);
        end

        cycle(1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        n_chk++;
        if (!mid_done) begin
            n_fail++;
            $display("FAIL mid_reset: got 0 resets expected 1");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
